// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the data-bus UART transmitter.
//   - register offsets (address bits [3:2])
//   - STATUS and CTRL bit positions
//   - serializer FSM state encoding
//   - parity helper
package uart_pkg;

    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_BAUDDIV = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    localparam int ST_BUSY    = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_EMPTY   = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_LVL_LSB = 8;

    localparam int CT_TXEN  = 0;
    localparam int CT_IRQEN = 1;
    localparam int CT_PODD  = 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } tx_state_t;

    // Parity bit for a byte: even parity when odd=0, odd parity when odd=1.
    function automatic logic parity_bit(input logic [7:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with show-ahead read port.
//   clk, rst   clock and synchronous active-high reset (pointers only)
//   push       write request; accepted when not full, or when full and popping
//   push_data  data written on an accepted push
//   pop        read request; ignored when empty
//   pop_data   entry at the head of the FIFO (valid while not empty)
//   full/empty derived from pointers carrying an extra wrap bit
//   level      number of stored entries, 0..DEPTH
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level    = wr_ptr - rd_ptr;
    assign rd_ok    = pop && !empty;
    // A pop in the same cycle frees a slot, so a full FIFO still takes the push.
    assign wr_ok    = push && (!full || rd_ok);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/dbus_uart_tx.sv
// dbus_uart_tx: memory-mapped 8N1 UART transmitter on the core data bus.
//   i_Clk, i_Rst              clock, synchronous active-high reset
//   i_WriteEn/_Addr/_Data     write port (address bits [3:2] decoded)
//   i_ReadEn/i_Read_Addr      read port  (address bits [3:2] decoded)
//   o_Read_Data               registered read data, 1-cycle latency
//   o_Tx                      serial line, idle high
//   o_Interrupt               level: IRQEN & FIFO empty & serializer idle
// Registers: 0 TXDATA(W), 1 STATUS(R, bit3 W1C), 2 BAUDDIV(RW), 3 CTRL(RW).
// Build option: define UART_TX_PARITY_EN to add a parity bit (CTRL.PODD
// selects odd parity); without it frames are plain 8N1.
module dbus_uart_tx
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 10,
    parameter int DIV_RST    = 867
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic              i_WriteEn,
    input  logic [ADDR_W-1:0] i_Write_Addr,
    input  logic [31:0]       i_Write_Data,
    input  logic              i_ReadEn,
    input  logic [ADDR_W-1:0] i_Read_Addr,
    output logic [31:0]       o_Read_Data,
    output logic              o_Tx,
    output logic              o_Interrupt
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]    wr_sel;
    logic [1:0]    rd_sel;
    logic          wr_txdata;
    logic          wr_status;
    logic          wr_baud;
    logic          wr_ctrl;
    logic          fifo_full;
    logic          fifo_empty;
    logic [LW-1:0] fifo_level;
    logic [7:0]    fifo_q;
    logic          pop;
    logic          ovf;
    logic          txen;
    logic          irqen;
    logic          podd;
    logic [15:0]   baud_div;
    logic [15:0]   bit_timer;
    logic          bit_done;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          busy;
    tx_state_t     state;
    logic [31:0]   status_word;
    logic          unused_bits;

    assign wr_sel    = i_Write_Addr[3:2];
    assign rd_sel    = i_Read_Addr[3:2];
    assign wr_txdata = i_WriteEn && (wr_sel == REG_TXDATA);
    assign wr_status = i_WriteEn && (wr_sel == REG_STATUS);
    assign wr_baud   = i_WriteEn && (wr_sel == REG_BAUDDIV);
    assign wr_ctrl   = i_WriteEn && (wr_sel == REG_CTRL);

    assign busy      = (state != S_IDLE);
    assign bit_done  = (bit_timer == 16'd0);
    // Pops happen on leaving IDLE or at the end of STOP, so frames chain with no gap.
    assign pop       = txen && !fifo_empty &&
                       ((state == S_IDLE) || ((state == S_STOP) && bit_done));

    assign status_word = {16'd0, 8'(fifo_level), 4'd0, ovf, fifo_empty, fifo_full, busy};
    assign unused_bits = ^{i_Write_Addr, i_Read_Addr, i_Write_Data};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (i_Clk),
        .rst       (i_Rst),
        .push      (wr_txdata),
        .push_data (i_Write_Data[7:0]),
        .pop       (pop),
        .pop_data  (fifo_q),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

`ifdef UART_TX_PARITY_EN
    logic par;
`else
    assign podd = 1'b0;
`endif

    // Register file
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            baud_div <= 16'(DIV_RST);
            txen     <= 1'b0;
            irqen    <= 1'b0;
            ovf      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            podd     <= 1'b0;
`endif
        end else begin
            if (wr_baud) baud_div <= i_Write_Data[15:0];
            if (wr_ctrl) begin
                txen  <= i_Write_Data[CT_TXEN];
                irqen <= i_Write_Data[CT_IRQEN];
`ifdef UART_TX_PARITY_EN
                podd  <= i_Write_Data[CT_PODD];
`endif
            end
            // An overflow in the same cycle as a W1C clear keeps OVF set.
            if (wr_txdata && fifo_full && !pop) begin
                ovf <= 1'b1;
            end else if (wr_status && i_Write_Data[ST_OVF]) begin
                ovf <= 1'b0;
            end
        end
    end

    // Read port: registered, so a same-cycle write is seen only on the next read.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            o_Read_Data <= 32'd0;
        end else if (i_ReadEn) begin
            case (rd_sel)
                REG_STATUS:  o_Read_Data <= status_word;
                REG_BAUDDIV: o_Read_Data <= {16'd0, baud_div};
                REG_CTRL:    o_Read_Data <= {29'd0, podd, irqen, txen};
                default:     o_Read_Data <= 32'd0;
            endcase
        end
    end

    // Serializer FSM; o_Tx is registered from the current state, so the line
    // lags the state by one cycle uniformly.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state       <= S_IDLE;
            bit_timer   <= 16'd0;
            bit_cnt     <= 3'd0;
            o_Tx        <= 1'b1;
            o_Interrupt <= 1'b0;
        end else begin
            o_Interrupt <= irqen && fifo_empty && !busy;

            case (state)
                S_START:  o_Tx <= 1'b0;
                S_DATA:   o_Tx <= shreg[0];
`ifdef UART_TX_PARITY_EN
                S_PARITY: o_Tx <= par;
`endif
                default:  o_Tx <= 1'b1;
            endcase

            if (pop) begin
                shreg     <= fifo_q;
`ifdef UART_TX_PARITY_EN
                par       <= parity_bit(fifo_q, podd);
`endif
                bit_timer <= baud_div;
                state     <= S_START;
            end else if (bit_done) begin
                // BAUDDIV is sampled only here, at bit boundaries.
                bit_timer <= baud_div;
                case (state)
                    S_IDLE: state <= S_IDLE;
                    S_START: begin
                        bit_cnt <= 3'd0;
                        state   <= S_DATA;
                    end
                    S_DATA: begin
                        shreg   <= shreg >> 1;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end
                    end
                    S_PARITY: state <= S_STOP;
                    S_STOP:   state <= S_IDLE;
                    default:  state <= S_IDLE;
                endcase
            end else begin
                bit_timer <= bit_timer - 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_dbus_uart_tx.sv
// tb_dbus_uart_tx: directed, table-driven bench for dbus_uart_tx.
module tb_dbus_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int          NB    = 11;
    localparam logic [31:0] CMASK = 32'h7;
`else
    localparam int          NB    = 10;
    localparam logic [31:0] CMASK = 32'h3;
`endif

    logic        clk;
    logic        rst;
    logic        we;
    logic [9:0]  waddr;
    logic [31:0] wdata;
    logic        re;
    logic [9:0]  raddr;
    logic [31:0] rdata;
    logic        tx;
    logic        irq;

    int errors = 0;
    int checks = 0;

    dbus_uart_tx #(
        .FIFO_DEPTH (16),
        .ADDR_W     (10),
        .DIV_RST    (867)
    ) dut (
        .i_Clk        (clk),
        .i_Rst        (rst),
        .i_WriteEn    (we),
        .i_Write_Addr (waddr),
        .i_Write_Data (wdata),
        .i_ReadEn     (re),
        .i_Read_Addr  (raddr),
        .o_Read_Data  (rdata),
        .o_Tx         (tx),
        .o_Interrupt  (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  wsel;
        logic [31:0] wd;
        logic        re;
        logic [1:0]  rsel;
        logic        chk;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vt[14];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called at a negedge; drives one bus cycle and returns at the next negedge.
    task automatic bus(input logic w, input logic [1:0] wsel, input logic [31:0] wd,
                       input logic r, input logic [1:0] rsel);
        we    = w;
        waddr = {6'h2A, wsel, 2'b00};
        wdata = wd;
        re    = r;
        raddr = {6'h15, rsel, 2'b01};
        @(negedge clk);
        we = 1'b0;
        re = 1'b0;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [31:0] d);
        bus(1'b1, sel, d, 1'b0, 2'd0);
    endtask

    task automatic rd_check(input logic [1:0] sel, input logic [31:0] exp, input string nm);
        bus(1'b0, 2'd0, 32'd0, 1'b1, sel);
        check(nm, rdata, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Checks NB bit times (4 cycles each at BAUDDIV=3), starting at the next
    // negedge. Optionally reads STATUS mid-frame and expects BUSY|EMPTY.
    task automatic expect_frame(input logic [7:0] b, input logic odd, input string nm,
                                input int rd_at);
        logic [10:0] bits;
        bits       = '1;
        bits[0]    = 1'b0;
        bits[8:1]  = b;
`ifdef UART_TX_PARITY_EN
        bits[9]    = (^b) ^ odd;
`endif
        for (int i = 0; i < NB * 4; i++) begin
            @(negedge clk);
            if (rd_at >= 0 && i == rd_at + 1) begin
                re = 1'b0;
                check({nm, "_busy"}, rdata, 32'h5);
            end
            check(nm, {31'd0, tx}, {31'd0, bits[i / 4]});
            if (rd_at >= 0 && i == rd_at) begin
                re    = 1'b1;
                raddr = 10'h004;
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        we    = 1'b0;
        waddr = '0;
        wdata = '0;
        re    = 1'b0;
        raddr = '0;

        // Register access table
        vt[0]  = '{1'b0, 2'd0, 32'h0,        1'b1, 2'd1, 1'b1, 32'h4,          "rst_status"};
        vt[1]  = '{1'b0, 2'd0, 32'h0,        1'b1, 2'd2, 1'b1, 32'd867,        "rst_baud"};
        vt[2]  = '{1'b0, 2'd0, 32'h0,        1'b1, 2'd3, 1'b1, 32'h0,          "rst_ctrl"};
        vt[3]  = '{1'b0, 2'd0, 32'h0,        1'b1, 2'd0, 1'b1, 32'h0,          "txdata_rd"};
        vt[4]  = '{1'b1, 2'd2, 32'hABCD1234, 1'b0, 2'd0, 1'b0, 32'h0,          "baud_wr"};
        vt[5]  = '{1'b0, 2'd0, 32'h0,        1'b1, 2'd2, 1'b1, 32'h1234,       "baud_rd"};
        vt[6]  = '{1'b1, 2'd2, 32'h5,        1'b1, 2'd2, 1'b1, 32'h1234,       "rw_same"};
        vt[7]  = '{1'b0, 2'd0, 32'h0,        1'b1, 2'd2, 1'b1, 32'h5,          "baud_rd2"};
        vt[8]  = '{1'b1, 2'd3, 32'h0,        1'b0, 2'd0, 1'b1, 32'h5,          "rd_hold"};
        vt[9]  = '{1'b1, 2'd3, 32'hFFFFFFFE, 1'b1, 2'd3, 1'b1, 32'h0,          "ctrl_rw_same"};
        vt[10] = '{1'b0, 2'd0, 32'h0,        1'b1, 2'd3, 1'b1, 32'h6 & CMASK,  "ctrl_rd"};
        vt[11] = '{1'b1, 2'd3, 32'h0,        1'b1, 2'd1, 1'b1, 32'h4,          "status_rd"};
        vt[12] = '{1'b1, 2'd2, 32'h0,        1'b0, 2'd0, 1'b0, 32'h0,          "baud_zero_wr"};
        vt[13] = '{1'b0, 2'd0, 32'h0,        1'b1, 2'd2, 1'b1, 32'h0,          "baud_zero_rd"};

        // Reset
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_tx",   {31'd0, tx},  32'd1);
        check("rst_irq",  {31'd0, irq}, 32'd0);
        check("rst_rdat", rdata,        32'd0);

        for (int i = 0; i < 14; i++) begin
            bus(vt[i].we, vt[i].wsel, vt[i].wd, vt[i].re, vt[i].rsel);
            if (vt[i].chk) check(vt[i].name, rdata, vt[i].exp);
        end

        // Single byte
        wr(2'd2, 32'd3);
        wr(2'd3, 32'd1);
        wr(2'd0, 32'hA5);
        check("a5_pre0", {31'd0, tx}, 32'd1);
        @(negedge clk);
        check("a5_pre1", {31'd0, tx}, 32'd1);
        expect_frame(8'hA5, 1'b0, "frame_a5", 20);
        rd_check(2'd1, 32'h4, "a5_idle_status");
        check("a5_idle_tx", {31'd0, tx}, 32'd1);

        // Back-to-back frames
        wr(2'd3, 32'd0);
        wr(2'd0, 32'h55);
        wr(2'd0, 32'hAA);
        wr(2'd3, 32'd1);
        check("b2b_pre0", {31'd0, tx}, 32'd1);
        @(negedge clk);
        check("b2b_pre1", {31'd0, tx}, 32'd1);
        expect_frame(8'h55, 1'b0, "frame_55", -1);
        expect_frame(8'hAA, 1'b0, "frame_aa", -1);
        @(negedge clk);
        check("b2b_post", {31'd0, tx}, 32'd1);

        // Overflow and full-with-pop
        do_reset();
        for (int i = 0; i < 17; i++) wr(2'd0, 32'(i));
        rd_check(2'd1, 32'h100A, "ovf_status");
        wr(2'd1, 32'h8);
        rd_check(2'd1, 32'h1002, "ovf_clear");
        wr(2'd3, 32'd1);
        wr(2'd0, 32'h77);
        rd_check(2'd1, 32'h1003, "full_pop_push");
        wr(2'd0, 32'h78);
        rd_check(2'd1, 32'h100B, "ovf_again");

        // Interrupt
        do_reset();
        wr(2'd2, 32'd3);
        wr(2'd3, 32'd3);
        @(negedge clk);
        check("irq_idle", {31'd0, irq}, 32'd1);
        wr(2'd0, 32'h3C);
        check("irq_after_wr", {31'd0, irq}, 32'd1);
        @(negedge clk);
        check("irq_fall", {31'd0, irq}, 32'd0);
        repeat (NB * 4) @(negedge clk);
        check("irq_stop_end", {31'd0, irq}, 32'd0);
        @(negedge clk);
        check("irq_rise", {31'd0, irq}, 32'd1);
        wr(2'd0, 32'h3D);
        check("irq_wr2", {31'd0, irq}, 32'd1);
        @(negedge clk);
        check("irq_fall2", {31'd0, irq}, 32'd0);

        // Reset mid-frame
        do_reset();
        wr(2'd2, 32'd3);
        wr(2'd3, 32'd1);
        wr(2'd0, 32'h00);
        wr(2'd0, 32'h00);
        repeat (21) @(negedge clk);
        check("mid_bit4", {31'd0, tx}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_tx", {31'd0, tx}, 32'd1);
        rst = 1'b0;
        rd_check(2'd1, 32'h4,   "mid_status");
        rd_check(2'd2, 32'd867, "mid_baud");
        rd_check(2'd3, 32'd0,   "mid_ctrl");
        wr(2'd3, 32'd1);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            check("mid_no_resid", {31'd0, tx}, 32'd1);
        end

`ifdef UART_TX_PARITY_EN
        // Parity build
        do_reset();
        wr(2'd2, 32'd3);
        wr(2'd3, 32'd1);
        wr(2'd0, 32'h07);
        @(negedge clk);
        expect_frame(8'h07, 1'b0, "par_even", -1);
        @(negedge clk);
        wr(2'd3, 32'd5);
        rd_check(2'd3, 32'h5, "par_ctrl");
        wr(2'd0, 32'h07);
        @(negedge clk);
        expect_frame(8'h07, 1'b1, "par_odd", -1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dbus_uart_tx.md
# dbus_uart_tx

Memory-mapped UART transmitter that sits on the core's data bus as a responder, alongside data memory. It uses the same read/write-enable, address and 32-bit data port set as data memory. The core writes bytes into a transmit FIFO, and a serializer sends them as 8N1 frames on `o_Tx`. The block raises a level interrupt when the FIFO has drained and the line is idle.

## Interface
- `FIFO_DEPTH`, default 16: transmit FIFO entries. Must be a power of two, ≥2.
- `ADDR_W`, default 10: data-bus address width.
- `DIV_RST`, default 867: reset value of BAUDDIV (115200 baud at 100 MHz).
- `i_Clk`  in  1  system clock; all logic is rising-edge.
- `i_Rst`  in  1  synchronous reset, active-high. One clock domain only.
- `i_WriteEn`  in  1  write strobe, one cycle per access.
- `i_Write_Addr`  in  ADDR_W  write byte address; only bits [3:2] are decoded.
- `i_Write_Data`  in  32  write data.
- `i_ReadEn`  in  1  read strobe.
- `i_Read_Addr`  in  ADDR_W  read byte address; only bits [3:2] are decoded.
- `o_Read_Data`  out  32  registered read data; reset value 0.
- `o_Tx`  out  1  serial line; idle high; reset value 1.
- `o_Interrupt`  out  1  TX-done interrupt, level; reset value 0.

## Operation
Registers, selected by address bits [3:2]:
- **0 TXDATA (W)**: pushes [7:0] into the FIFO.
  - A write while the FIFO is full is dropped and sets the sticky OVF bit.
  - A full FIFO that pops in the same cycle accepts the write.
  - Reads return 0.
- **1 STATUS (R)**:
  - bit0 BUSY (FSM not in IDLE)
  - bit1 FULL
  - bit2 EMPTY
  - bit3 OVF
  - [15:8] FIFO level
  - all other bits 0.
  - Writing 1 to bit3 clears OVF; if an overflow occurs in the same cycle, the set wins.
- **2 BAUDDIV (RW)**: [15:0] holds clocks-per-bit minus 1. Upper bits read 0. A value of 0 is legal (1 clock per bit).
- **3 CTRL (RW)**: bit0 TXEN, bit1 IRQEN, bit2 PODD (parity build only, otherwise reads 0). Reset value is 0.

Reads and writes:
- A read and a write to the same register in the same cycle: the read returns the pre-write value.
- `o_Read_Data` holds its last value when `i_ReadEn` is low.

Serializer FSM (IDLE, START, DATA, [PARITY], STOP):
- IDLE → START when TXEN=1 and the FIFO is non-empty. The transition pops one byte into the shift register.
- START drives 0 for one bit time.
- DATA sends 8 bits, LSB first. A 3-bit counter counts the bits.
- STOP drives 1 for one bit time. It then goes to START (immediate pop) if TXEN=1 and the FIFO is non-empty; otherwise it goes to IDLE.
- A 16-bit bit timer reloads with BAUDDIV at each bit boundary. A BAUDDIV write therefore takes effect at the next bit boundary and never stretches the current bit.
- Clearing TXEN mid-frame lets the current frame complete; no further pops occur.

Interrupt:
- `o_Interrupt` is registered as IRQEN & EMPTY & ~BUSY.

## Timing
- Read latency is 1 cycle: `i_ReadEn` at edge n gives data valid after edge n.
- A TXDATA write at edge n is visible in the FIFO level after edge n.
- With the FSM idle and TXEN=1, the pop happens at edge n+1 and `o_Tx` falls after edge n+2.
- One bit lasts BAUDDIV+1 cycles. An 8N1 frame lasts 10·(BAUDDIV+1) cycles.
- Back-to-back frames have no idle gap between the STOP bit and the next START bit.
- `o_Interrupt` rises one cycle after the FSM re-enters IDLE with the FIFO empty.
- Reset mid-frame: the next edge forces `o_Tx`=1, puts the FSM in IDLE, empties the FIFO, clears OVF/CTRL/interrupt and reloads BAUDDIV=DIV_RST. The partial frame is abandoned.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - adds the PARITY state between DATA and STOP;
  - the parity bit is even parity when PODD=0 and odd parity when PODD=1;
  - CTRL bit2 becomes writable;
  - a frame lasts 11·(BAUDDIV+1) cycles.
- Undefined: no parity state; CTRL bit2 reads 0 and ignores writes.

## Structure
- A shared package `uart_pkg` holds:
  - register offsets (TXDATA=0, STATUS=1, BAUDDIV=2, CTRL=3);
  - STATUS and CTRL bit indices;
  - the FSM state encoding.
- One sub-module, `sync_fifo` (parameters WIDTH=8 and DEPTH).
  - Interface: push, pop, data, full, empty, level.
  - Pointers have an extra wrap bit; full/empty are computed from the pointers.
- Register decode, the FSM, the bit timer and the shift register live in `dbus_uart_tx`.

## Test plan
- **Reset**: assert `i_Rst` for 2 cycles → `o_Tx`=1, `o_Interrupt`=0, STATUS read = 0x0000_0004, BAUDDIV read = 867.
- **Single byte**: BAUDDIV=3, CTRL=1, TXDATA=0xA5 → `o_Tx` falls 2 cycles after the write. Line sequence is 0, 1,0,1,0,0,1,0,1, 1, with each bit lasting 4 cycles. BUSY=0 after 40 cycles.
- **Back-to-back**: with TXEN=0, write 0x55 then 0xAA, then set TXEN=1 → two frames with zero idle cycles between the STOP and the second START.
- **Overflow**: with TXEN=0, write 17 bytes → STATUS = 0x0000_100A (level 16, FULL, OVF). Writing 0x8 to STATUS clears OVF only.
- **Interrupt**: set CTRL=3, send one byte → `o_Interrupt` rises 1 cycle after the STOP bit ends and falls the cycle after the next TXDATA write.
- **Reset mid-frame**: assert `i_Rst` during DATA bit 4 → `o_Tx`=1 after the edge, the FIFO is empty, and no residual frame is sent after release.
- **Parity build (`UART_TX_PARITY_EN`)**: send byte 0x07 → parity bit is 1 with PODD=0 and 0 with PODD=1.
